// File: rtl/plic_core_if.sv
// Word-wide request/acknowledge slave bus used by the D-bus master to reach plic_core.
interface plic_core_if;
  logic        req;
  logic        we;
  logic [21:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/plic_core.sv
// Single-context platform-level interrupt controller: per-source gateways, priority
// arbitration against a threshold, and a claim/complete register interface.
module plic_core #(
  parameter int          NSRC      = 8,
  parameter int          PRIO_W    = 3,
  parameter logic [31:0] EDGE_MASK = 32'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NSRC:0] irq_src,
  plic_core_if.slave    bus,
  output logic          irq_ext
);

  localparam logic [19:0] PEND_WORD  = 20'h00400;
  localparam logic [19:0] EN_WORD    = 20'h00800;
  localparam logic [19:0] THR_WORD   = 20'h80000;
  localparam logic [19:0] CLAIM_WORD = 20'h80001;

  logic [PRIO_W-1:0] prio_r [NSRC:1];
  logic [NSRC:1]     enable_r;
  logic [NSRC:1]     pending_r;
  logic [NSRC:1]     inflight_r;
  logic [NSRC:1]     prev_src_r;
  logic [PRIO_W-1:0] threshold_r;
  logic              ack_r;
  logic              lock_r;
  logic              irq_ext_r;
  logic [31:0]       rdata_r;

  logic [19:0]       word_s;
  logic              accept_s;
  logic              wr_fire_s;
  logic              rd_fire_s;
  logic              claim_fire_s;
  logic              cpl_fire_s;
  logic [4:0]        cpl_id_s;
  logic [4:0]        win_id_s;
  logic [PRIO_W-1:0] win_prio_s;
  logic              elig_any_s;
  logic              elig_s;
  logic              take_s;
  logic [NSRC:1]     prio_hit_s;
  logic [NSRC:1]     set_s;
  logic [NSRC:1]     claim_clr_s;
  logic [NSRC:1]     cpl_clr_s;
  logic [31:0]       rd_s;
  logic              unused_s;

  assign unused_s  = ^{irq_src[0], bus.addr[1:0], bus.wdata};
  assign bus.ack   = ack_r;
  assign bus.rdata = rdata_r;
  assign irq_ext   = irq_ext_r;

  // Arbitration: strict '>' while scanning upward keeps the lowest ID on priority ties.
  always_comb begin
    win_id_s   = 5'd0;
    win_prio_s = {PRIO_W{1'b0}};
    elig_any_s = 1'b0;
    elig_s     = 1'b0;
    take_s     = 1'b0;
    for (int i = 1; i <= NSRC; i++) begin
      elig_s     = pending_r[i] & enable_r[i] & (prio_r[i] > threshold_r);
      take_s     = elig_s & (prio_r[i] > win_prio_s);
      elig_any_s = elig_any_s | elig_s;
      win_id_s   = take_s ? 5'(i) : win_id_s;
      win_prio_s = take_s ? prio_r[i] : win_prio_s;
    end
  end

  // Bus decode, gateway set terms and claim/complete targets.
  always_comb begin
    word_s       = bus.addr[21:2];
    accept_s     = bus.req & ~ack_r & ~lock_r;
    wr_fire_s    = accept_s & bus.we;
    rd_fire_s    = accept_s & ~bus.we;
    claim_fire_s = rd_fire_s & (word_s == CLAIM_WORD) & elig_any_s;
    cpl_fire_s   = wr_fire_s & (word_s == CLAIM_WORD);
    cpl_id_s     = bus.wdata[4:0];
    prio_hit_s   = {NSRC{1'b0}};
    set_s        = {NSRC{1'b0}};
    claim_clr_s  = {NSRC{1'b0}};
    cpl_clr_s    = {NSRC{1'b0}};
    for (int i = 1; i <= NSRC; i++) begin
      prio_hit_s[i]  = (word_s == 20'(i));
      claim_clr_s[i] = claim_fire_s & (win_id_s == 5'(i));
      cpl_clr_s[i]   = cpl_fire_s & (cpl_id_s == 5'(i)) & inflight_r[i];
      // Edge sources pend on every rising edge; level sources wait for the previous one to retire.
      set_s[i]       = EDGE_MASK[i] ? (irq_src[i] & ~prev_src_r[i])
                                    : (irq_src[i] & ~inflight_r[i] & ~pending_r[i]);
    end
  end

  // Read data multiplexer; anything unmapped reads as zero.
  always_comb begin
    rd_s = 32'h0;
    case (word_s)
      PEND_WORD:  rd_s = 32'({pending_r, 1'b0});
      EN_WORD:    rd_s = 32'({enable_r, 1'b0});
      THR_WORD:   rd_s = 32'(threshold_r);
      CLAIM_WORD: rd_s = 32'(win_id_s);
      default: begin
        for (int i = 1; i <= NSRC; i++) begin
          rd_s = prio_hit_s[i] ? 32'(prio_r[i]) : rd_s;
        end
      end
    endcase
  end

  // Register file, gateway state, handshake and the registered interrupt output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= NSRC; i++) begin
        prio_r[i] <= {PRIO_W{1'b0}};
      end
      enable_r    <= {NSRC{1'b0}};
      pending_r   <= {NSRC{1'b0}};
      inflight_r  <= {NSRC{1'b0}};
      prev_src_r  <= {NSRC{1'b0}};
      threshold_r <= {PRIO_W{1'b0}};
      ack_r       <= 1'b0;
      lock_r      <= 1'b0;
      irq_ext_r   <= 1'b0;
      rdata_r     <= 32'h0;
    end else begin
      ack_r      <= accept_s;
      lock_r     <= accept_s | (lock_r & bus.req);
      rdata_r    <= rd_fire_s ? rd_s : 32'h0;
      irq_ext_r  <= elig_any_s;
      prev_src_r <= irq_src[NSRC:1];
      pending_r  <= (pending_r & ~claim_clr_s) | set_s;
      inflight_r <= (inflight_r | claim_clr_s) & ~cpl_clr_s;
      if (wr_fire_s && (word_s == EN_WORD)) begin
        enable_r <= bus.wdata[NSRC:1];
      end else begin
        enable_r <= enable_r;
      end
      if (wr_fire_s && (word_s == THR_WORD)) begin
        threshold_r <= bus.wdata[PRIO_W-1:0];
      end else begin
        threshold_r <= threshold_r;
      end
      for (int i = 1; i <= NSRC; i++) begin
        if (wr_fire_s && prio_hit_s[i]) begin
          prio_r[i] <= bus.wdata[PRIO_W-1:0];
        end else begin
          prio_r[i] <= prio_r[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_plic_core.sv
// Directed self-checking bench for plic_core (NSRC=8, PRIO_W=3, source 4 edge-triggered).
module tb_plic_core;
  localparam int          NSRC      = 8;
  localparam int          PRIO_W    = 3;
  localparam logic [31:0] EDGE_MASK = 32'h0000_0010;
  localparam logic [21:0] PEND_A    = 22'h001000;
  localparam logic [21:0] EN_A      = 22'h002000;
  localparam logic [21:0] THR_A     = 22'h200000;
  localparam logic [21:0] CLAIM_A   = 22'h200004;

  logic          clk;
  logic          rst_n;
  logic [NSRC:0] irq_src;
  logic          irq_ext;
  int            checks;
  int            errors;

  plic_core_if bus ();

  plic_core #(.NSRC(NSRC), .PRIO_W(PRIO_W), .EDGE_MASK(EDGE_MASK)) dut (
    .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .bus(bus), .irq_ext(irq_ext)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One bus transfer; returns read data and the number of cycles until ack.
  task automatic xfer(input logic w, input logic [21:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int lat);
    logic seen;
    @(posedge clk); #1;
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    lat = 0; seen = 1'b0; rd = 32'h0;
    while (!seen && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      seen = bus.ack;
    end
    rd = bus.rdata;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL bus_timeout addr %h got no ack exp ack within 1 cycle", a);
      lat = 99;
    end
    bus.req = 1'b0; bus.we = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r; int l;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", bus.ack); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.rdata); end
    checks++; if (irq_ext !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq_ext); end
    rst_n = 1'b1;
    xfer(1'b0, PEND_A, 32'h0, r, l);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rst_pend got %h exp 0", r); end
    xfer(1'b0, 22'h00000C, 32'h0, r, l);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rst_prio3 got %h exp 0", r); end
    xfer(1'b0, CLAIM_A, 32'h0, r, l);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rst_claim got %h exp 0", r); end
    checks++; if (l !== 1) begin errors++; $display("FAIL rst_lat got %0d exp 1", l); end
  endtask

  task automatic test_level();
    logic [31:0] r; int l;
    xfer(1'b1, 22'h00000C, 32'd2, r, l);
    xfer(1'b1, EN_A, 32'h8, r, l);
    xfer(1'b1, THR_A, 32'h0, r, l);
    @(posedge clk); #1; irq_src[3] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (irq_ext !== 1'b1) begin errors++; $display("FAIL lvl_irq_up got %b exp 1", irq_ext); end
    xfer(1'b0, CLAIM_A, 32'h0, r, l);
    checks++; if (r !== 32'd3) begin errors++; $display("FAIL lvl_claim got %h exp 3", r); end
    @(posedge clk); #1;
    checks++; if (irq_ext !== 1'b0) begin errors++; $display("FAIL lvl_irq_drop got %b exp 0", irq_ext); end
    repeat (3) @(posedge clk);
    xfer(1'b0, PEND_A, 32'h0, r, l);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL lvl_no_repend got %h exp 0", r); end
    xfer(1'b1, CLAIM_A, 32'd3, r, l);
    xfer(1'b0, PEND_A, 32'h0, r, l);
    checks++; if (r !== 32'h8) begin errors++; $display("FAIL lvl_repend got %h exp 8", r); end
    irq_src[3] = 1'b0;
    xfer(1'b0, CLAIM_A, 32'h0, r, l);
    checks++; if (r !== 32'd3) begin errors++; $display("FAIL lvl_claim2 got %h exp 3", r); end
    xfer(1'b1, CLAIM_A, 32'd3, r, l);
  endtask

  task automatic test_arbitration();
    logic [31:0] r; int l;
    xfer(1'b1, 22'h000008, 32'd4, r, l);
    xfer(1'b1, 22'h000014, 32'd4, r, l);
    xfer(1'b1, EN_A, 32'h24, r, l);
    irq_src[2] = 1'b1; irq_src[5] = 1'b1;
    repeat (2) @(posedge clk);
    xfer(1'b0, CLAIM_A, 32'h0, r, l);
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL arb_tie got %h exp 2", r); end
    xfer(1'b1, CLAIM_A, 32'd2, r, l);
    xfer(1'b1, 22'h000014, 32'd6, r, l);
    xfer(1'b0, CLAIM_A, 32'h0, r, l);
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL arb_prio got %h exp 5", r); end
    xfer(1'b1, CLAIM_A, 32'd5, r, l);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (irq_ext !== 1'b1) begin errors++; $display("FAIL arb_irq_up got %b exp 1", irq_ext); end
    xfer(1'b1, THR_A, 32'd6, r, l);
    @(posedge clk); #1;
    checks++; if (irq_ext !== 1'b0) begin errors++; $display("FAIL arb_thr_irq got %b exp 0", irq_ext); end
    xfer(1'b0, CLAIM_A, 32'h0, r, l);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL arb_thr_claim got %h exp 0", r); end
    xfer(1'b0, PEND_A, 32'h0, r, l);
    checks++; if (r !== 32'h24) begin errors++; $display("FAIL arb_thr_pend got %h exp 24", r); end
    irq_src[2] = 1'b0; irq_src[5] = 1'b0;
    xfer(1'b1, THR_A, 32'd0, r, l);
    xfer(1'b0, CLAIM_A, 32'h0, r, l);
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL arb_cln5 got %h exp 5", r); end
    xfer(1'b1, CLAIM_A, 32'd5, r, l);
    xfer(1'b0, CLAIM_A, 32'h0, r, l);
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL arb_cln2 got %h exp 2", r); end
    xfer(1'b1, CLAIM_A, 32'd2, r, l);
    xfer(1'b1, EN_A, 32'h0, r, l);
  endtask

  task automatic test_edge();
    logic [31:0] r; int l;
    xfer(1'b1, 22'h000010, 32'd3, r, l);
    xfer(1'b1, EN_A, 32'h10, r, l);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1; irq_src[4] = 1'b1;
      @(posedge clk); #1; irq_src[4] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (irq_ext !== 1'b1) begin errors++; $display("FAIL edge_irq got %b exp 1", irq_ext); end
    xfer(1'b0, CLAIM_A, 32'h0, r, l);
    checks++; if (r !== 32'd4) begin errors++; $display("FAIL edge_claim got %h exp 4", r); end
    xfer(1'b0, CLAIM_A, 32'h0, r, l);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL edge_coalesce got %h exp 0", r); end
    @(posedge clk); #1; irq_src[4] = 1'b1;
    @(posedge clk); #1; irq_src[4] = 1'b0;
    // Claim accepted on the same edge that sees a fresh rising edge.
    @(posedge clk); #1;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = CLAIM_A; irq_src[4] = 1'b1;
    @(posedge clk); #1;
    irq_src[4] = 1'b0;
    checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL edge_sim_ack got %b exp 1", bus.ack); end
    checks++; if (bus.rdata !== 32'd4) begin errors++; $display("FAIL edge_sim_claim got %h exp 4", bus.rdata); end
    bus.req = 1'b0;
    xfer(1'b0, PEND_A, 32'h0, r, l);
    checks++; if (r !== 32'h10) begin errors++; $display("FAIL edge_sim_pend got %h exp 10", r); end
    xfer(1'b0, CLAIM_A, 32'h0, r, l);
    checks++; if (r !== 32'd4) begin errors++; $display("FAIL edge_reclaim got %h exp 4", r); end
    xfer(1'b1, CLAIM_A, 32'd4, r, l);
    xfer(1'b1, EN_A, 32'h0, r, l);
  endtask

  task automatic test_complete_ignored();
    logic [31:0] r; int l;
    logic [31:0] ids [3];
    ids[0] = 32'd0; ids[1] = 32'd9; ids[2] = 32'd3;
    xfer(1'b1, 22'h000004, 32'd1, r, l);
    xfer(1'b1, EN_A, 32'h2, r, l);
    irq_src[1] = 1'b1;
    repeat (2) @(posedge clk);
    xfer(1'b0, CLAIM_A, 32'h0, r, l);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL cpl_claim1 got %h exp 1", r); end
    for (int k = 0; k < 3; k++) begin
      xfer(1'b1, CLAIM_A, ids[k], r, l);
      checks++; if (l !== 1) begin errors++; $display("FAIL cpl_lat id %0d got %0d exp 1", ids[k], l); end
      @(posedge clk); #1;
      checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL cpl_ack_width id %0d got %b exp 0", ids[k], bus.ack); end
    end
    repeat (2) @(posedge clk);
    xfer(1'b0, PEND_A, 32'h0, r, l);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL cpl_ignored_pend got %h exp 0", r); end
    xfer(1'b1, CLAIM_A, 32'd1, r, l);
    xfer(1'b0, PEND_A, 32'h0, r, l);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL cpl_valid_pend got %h exp 2", r); end
    irq_src[1] = 1'b0;
    xfer(1'b0, CLAIM_A, 32'h0, r, l);
    xfer(1'b1, CLAIM_A, 32'd1, r, l);
    xfer(1'b1, EN_A, 32'h0, r, l);
  endtask

  task automatic test_req_hold();
    @(posedge clk); #1;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = THR_A;
    @(posedge clk); #1;
    checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL hold_first_ack got %b exp 1", bus.ack); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL hold_no_ack cyc %0d got %b exp 0", k, bus.ack); end
    end
    bus.req = 1'b0;
    @(posedge clk); #1;
    bus.req = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL hold_second_ack got %b exp 1", bus.ack); end
    bus.req = 1'b0;
  endtask

  task automatic test_reads();
    logic [31:0] r; int l;
    xfer(1'b1, 22'h00001C, 32'hFFFF_FFFD, r, l);
    xfer(1'b0, 22'h00001C, 32'h0, r, l);
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL rd_prio7 got %h exp 5", r); end
    xfer(1'b1, EN_A, 32'hFFFF_FFFF, r, l);
    xfer(1'b0, EN_A, 32'h0, r, l);
    checks++; if (r !== 32'h1FE) begin errors++; $display("FAIL rd_en got %h exp 1fe", r); end
    xfer(1'b0, 22'h000000, 32'h0, r, l);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rd_prio0 got %h exp 0", r); end
    xfer(1'b0, 22'h000024, 32'h0, r, l);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rd_prio9 got %h exp 0", r); end
    irq_src[0] = 1'b1; irq_src[2] = 1'b1;
    repeat (2) @(posedge clk);
    xfer(1'b0, 22'h001003, 32'h0, r, l);
    checks++; if (r !== 32'h4) begin errors++; $display("FAIL rd_pend got %h exp 4", r); end
    xfer(1'b0, 22'h100000, 32'h0, r, l);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rd_unmapped got %h exp 0", r); end
    checks++; if (l !== 1) begin errors++; $display("FAIL rd_unmapped_lat got %0d exp 1", l); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] r; int l;
    xfer(1'b1, EN_A, 32'h8, r, l);
    irq_src[3] = 1'b1;
    repeat (2) @(posedge clk);
    xfer(1'b0, CLAIM_A, 32'h0, r, l);
    checks++; if (r !== 32'd3) begin errors++; $display("FAIL mid_claim got %h exp 3", r); end
    @(posedge clk); #1;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = PEND_A;
    #2;
    rst_n = 1'b0; irq_src = '0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL mid_ack cyc %0d got %b exp 0", k, bus.ack); end
      checks++; if (irq_ext !== 1'b0) begin errors++; $display("FAIL mid_irq cyc %0d got %b exp 0", k, irq_ext); end
    end
    bus.req = 1'b0;
    rst_n = 1'b1;
    xfer(1'b0, PEND_A, 32'h0, r, l);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL mid_pend got %h exp 0", r); end
    xfer(1'b0, EN_A, 32'h0, r, l);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL mid_en got %h exp 0", r); end
    xfer(1'b0, 22'h00001C, 32'h0, r, l);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL mid_prio7 got %h exp 0", r); end
    xfer(1'b1, 22'h00000C, 32'd2, r, l);
    xfer(1'b1, EN_A, 32'h8, r, l);
    irq_src[3] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (irq_ext !== 1'b1) begin errors++; $display("FAIL mid_irq_again got %b exp 1", irq_ext); end
    xfer(1'b0, CLAIM_A, 32'h0, r, l);
    checks++; if (r !== 32'd3) begin errors++; $display("FAIL mid_reclaim got %h exp 3", r); end
    irq_src[3] = 1'b0;
    xfer(1'b1, CLAIM_A, 32'd3, r, l);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; irq_src = '0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 22'h0; bus.wdata = 32'h0;
    test_reset();
    test_level();
    test_arbitration();
    test_edge();
    test_complete_ignored();
    test_req_hold();
    test_reads();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
